heu_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the heuristic (HEU) unit.
//  - Accepts one input block from the IPGU and runs NUM_PASSES rotate/calc passes.
//  - Each pass ends with a sum handshake. After the last pass, the block shifts
//    the result out and hands off to the RDN.
//  - Generalises the fixed 80-cycle single-pass controller: rotate and shift

---
 rtl/heu_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_heu_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heu_seq_ctrl.sv
// Sequencer for the HEU unit: per input block, NUM_PASSES rotate/calc passes with sum handshakes.
// Optional sum-wait timeout and sticky error state are enabled by defining HEU_SUM_TIMEOUT_EN.
module heu_seq_ctrl #(
  parameter int unsigned ROT_CYCLES   = 80,
  parameter int unsigned SHIFT_CYCLES = 80,
  parameter int unsigned NUM_PASSES   = 1,
  parameter int unsigned SUM_TIMEOUT  = 256,
  localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ipgu_out_ready,
  input  logic          sum_ready,
  input  logic          rdn_in_ready,
  output logic          in_ready,
  output logic          write_in,
  output logic          zero_cnts,
  output logic          rotate_in,
  output logic          enable_calc,
  output logic          sum_go,
  output logic          shift_out,
  output logic          out_ready,
  output logic          busy,
  output logic [PW-1:0] cur_pass,
  output logic          err_timeout
);

  localparam int unsigned MaxCycles = (ROT_CYCLES > SHIFT_CYCLES) ? ROT_CYCLES : SHIFT_CYCLES;
  localparam int unsigned CW = $clog2(MaxCycles + 1);
  localparam logic [CW-1:0] RotLast   = CW'(ROT_CYCLES);
  localparam logic [CW-1:0] ShiftLast = CW'(SHIFT_CYCLES);
  localparam logic [PW-1:0] PassLast  = PW'(NUM_PASSES - 1);

  if (ROT_CYCLES < 1 || SHIFT_CYCLES < 1 || NUM_PASSES < 1 || SUM_TIMEOUT < 1) begin : gen_param_check
    $error("heu_seq_ctrl: all parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StDoSum,
    StMove,
    StDone
`ifdef HEU_SUM_TIMEOUT_EN
    , StErr
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pass_q, pass_d;

`ifdef HEU_SUM_TIMEOUT_EN
  localparam int unsigned WW = $clog2(SUM_TIMEOUT + 1);
  localparam logic [WW-1:0] WaitLast = WW'(SUM_TIMEOUT - 1);

  logic [WW-1:0]   wait_q, wait_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pass_q  <= '0;
`ifdef HEU_SUM_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
`ifdef HEU_SUM_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
`ifdef HEU_SUM_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ipgu_out_ready) begin
          cnt_d   = '0;
          pass_d  = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q < RotLast) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
`ifdef HEU_SUM_TIMEOUT_EN
          wait_d = '0;
`endif
          state_d = StDoSum;
        end
      end
      StDoSum: begin
        // A sum_ready arriving on the final allowed wait cycle takes priority over the timeout.
        if (sum_ready) begin
          cnt_d = '0;
          if (pass_q == PassLast) begin
            state_d = StMove;
          end else begin
            pass_d  = pass_q + PW'(1);
            state_d = StCalc;
          end
        end
`ifdef HEU_SUM_TIMEOUT_EN
        else if (wait_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + WW'(1);
        end
`endif
      end
      StMove: begin
        if (cnt_q < ShiftLast) begin
          cnt_d = cnt_q + CW'(1);
        end else if (rdn_in_ready) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (rdn_in_ready) begin
          state_d = StIdle;
        end
      end
`ifdef HEU_SUM_TIMEOUT_EN
      StErr: state_d = StErr;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Every output is forced low while rst is asserted so no strobe escapes during reset.
  always_comb begin
    in_ready    = 1'b0;
    write_in    = 1'b0;
    zero_cnts   = 1'b0;
    rotate_in   = 1'b0;
    enable_calc = 1'b0;
    sum_go      = 1'b0;
    shift_out   = 1'b0;
    out_ready   = 1'b0;
    busy        = 1'b0;
    err_timeout = 1'b0;
    cur_pass    = rst ? '0 : pass_q;
    if (!rst) begin
      busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          in_ready  = 1'b1;
          write_in  = ipgu_out_ready;
          zero_cnts = ipgu_out_ready;
        end
        StCalc: begin
          rotate_in   = (cnt_q < RotLast);
          enable_calc = (cnt_q < RotLast);
          sum_go      = (cnt_q == RotLast);
        end
        StDoSum: ;
        StMove: begin
          shift_out = (cnt_q < ShiftLast);
          out_ready = (cnt_q == ShiftLast);
        end
        StDone: out_ready = 1'b1;
`ifdef HEU_SUM_TIMEOUT_EN
        StErr: err_timeout = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heu_seq_ctrl.sv
// Randomized scoreboard bench for heu_seq_ctrl: per-block expected timing and strobe counts
// derived from pass/handshake arithmetic, plus directed reset and (optional) timeout checks.
module tb_heu_seq_ctrl;

  localparam int ROT = 7;
  localparam int SHIFT = 5;
  localparam int NP = 3;
  localparam int TO = 16;
  localparam int PWT = 2;
  localparam int BUDGET = 2000;

  logic clk, rst, ipgu_out_ready, sum_ready, rdn_in_ready;
  logic in_ready, write_in, zero_cnts, rotate_in, enable_calc, sum_go, shift_out, out_ready;
  logic busy, err_timeout;
  logic [PWT-1:0] cur_pass;
  logic [9:0] outs;

  assign outs = {in_ready, write_in, zero_cnts, rotate_in, enable_calc, sum_go, shift_out,
                 out_ready, busy, err_timeout};

  heu_seq_ctrl #(
    .ROT_CYCLES  (ROT),
    .SHIFT_CYCLES(SHIFT),
    .NUM_PASSES  (NP),
    .SUM_TIMEOUT (TO)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ipgu_out_ready(ipgu_out_ready),
    .sum_ready     (sum_ready),
    .rdn_in_ready  (rdn_in_ready),
    .in_ready      (in_ready),
    .write_in      (write_in),
    .zero_cnts     (zero_cnts),
    .rotate_in     (rotate_in),
    .enable_calc   (enable_calc),
    .sum_go        (sum_go),
    .shift_out     (shift_out),
    .out_ready     (out_ready),
    .busy          (busy),
    .cur_pass      (cur_pass),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rot;
    int sg;
    int sh;
    int fsg;
    int fsh;
    int hand;
    int oc;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Drives n blocks: random idle gaps, per-pass sum delays, RDN stall, and noise on ignored inputs.
  task automatic run_blocks(input int n);
    int done_blocks = 0;
    int budget = 0;
    bit pending = 1'b0;
    int gap = $urandom % 3;
    int pass_i = 0;
    int sw = -1;
    int out_seen = 0;
    int r = 0;
    int d[NP];
    int dsum;
    bit sg_prev = 1'b0;
    exp_t e;
    while (done_blocks < n) begin
      @(negedge clk);
      budget++;
      if (budget > BUDGET) begin
        fail("block_budget");
        return;
      end
      if (sg_prev) sw = d[pass_i];
      if (sw >= 0) begin
        sum_ready = (sw == 0);
        if (sw == 0) pass_i++;
        sw--;
      end else begin
        sum_ready = 1'($urandom % 2);
      end
      if (pending && out_ready) begin
        rdn_in_ready = (out_seen == r);
        out_seen++;
        if (rdn_in_ready) begin
          pending = 1'b0;
          done_blocks++;
          gap = $urandom % 3;
        end
      end else begin
        rdn_in_ready = 1'($urandom % 2);
      end
      if (!pending && in_ready) begin
        if (gap > 0) begin
          ipgu_out_ready = 1'b0;
          gap--;
        end else begin
          ipgu_out_ready = 1'b1;
          pending = 1'b1;
          pass_i = 0;
          out_seen = 0;
          r = $urandom % 4;
          dsum = 0;
          for (int p = 0; p < NP; p++) begin
            d[p] = ($urandom % 4 == 0) ? TO - 1 : int'($urandom % 4);
            dsum += d[p];
          end
          e.rot  = NP * ROT;
          e.sg   = NP;
          e.sh   = SHIFT;
          e.fsg  = ROT + 1;
          e.fsh  = NP * (ROT + 2) + dsum + 1;
          e.hand = NP * (ROT + 2) + dsum + SHIFT + 1 + r;
          e.oc   = r + 1;
          sb.push_back(e);
        end
      end else begin
        ipgu_out_ready = 1'($urandom % 2);
      end
      #1;
      sg_prev = sum_go;
    end
    ipgu_out_ready = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: gathers per-block observations and compares them at the RDN handoff.
  initial begin
    bit in_blk = 1'b0;
    bit ok = 1'b1;
    int c = 0, rot = 0, sg = 0, sh = 0, oc = 0, fsg = -1, fsh = -1, extra_w = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst) begin
        if (write_in) begin
          if (in_blk) begin
            extra_w++;
            c++;
          end else begin
            in_blk = 1'b1;
            ok = 1'b1;
            c = 0; rot = 0; sg = 0; sh = 0; oc = 0; fsg = -1; fsh = -1; extra_w = 0;
          end
        end else if (in_blk) begin
          c++;
        end
        if (in_blk) begin
          ok &= (enable_calc == rotate_in) && (zero_cnts == write_in) && (busy != in_ready)
                && !err_timeout;
          if (rotate_in) rot++;
          if (sum_go) begin
            check("pass_at_sum_go", int'(cur_pass), sg);
            if (fsg < 0) fsg = c;
            sg++;
          end
          if (shift_out) begin
            if (fsh < 0) fsh = c;
            sh++;
          end
          if (out_ready) oc++;
          if (out_ready && rdn_in_ready) begin
            in_blk = 1'b0;
            if (sb.size() == 0) begin
              check("unexpected_handoff", 1, 0);
            end else begin
              e = sb.pop_front();
              check("rotate_count", rot, e.rot);
              check("sum_go_count", sg, e.sg);
              check("shift_count", sh, e.sh);
              check("first_sum_go_cycle", fsg, e.fsg);
              check("first_shift_cycle", fsh, e.fsh);
              check("handoff_cycle", c, e.hand);
              check("out_ready_cycles", oc, e.oc);
              check("extra_write_in", extra_w, 0);
              check("strobe_consistency", int'(ok), 1);
            end
          end
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    ipgu_out_ready = 1'b1;
    sum_ready = 1'b1;
    rdn_in_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("outputs_in_reset", int'(outs), 0);
    check("cur_pass_in_reset", int'(cur_pass), 0);
    @(negedge clk);
    rst = 1'b0;
    ipgu_out_ready = 1'b0;
    #1;
    check("in_ready_after_reset", int'(in_ready), 1);
    check("busy_after_reset", int'(busy), 0);

    mon_en = 1'b1;
    run_blocks(8);
    mon_en = 1'b0;

    // Reset in the middle of the second pass.
    ipgu_out_ready = 1'b1;
    sum_ready = 1'b1;
    rdn_in_ready = 1'b1;
    repeat (ROT + 5) begin
      @(negedge clk);
      ipgu_out_ready = 1'b0;
    end
    #1;
    check("mid_pass_cur_pass", int'(cur_pass), 1);
    check("mid_pass_rotating", int'(rotate_in), 1);
    rst = 1'b1;
    ipgu_out_ready = 1'b1;
    #1;
    check("outputs_mid_reset", int'(outs), 0);
    @(negedge clk);
    rst = 1'b0;
    ipgu_out_ready = 1'b0;
    #1;
    check("idle_after_mid_reset", int'(in_ready), 1);
    check("busy_after_mid_reset", int'(busy), 0);
    check("pass_after_mid_reset", int'(cur_pass), 0);

    mon_en = 1'b1;
    run_blocks(4);
    mon_en = 1'b0;

`ifdef HEU_SUM_TIMEOUT_EN
    ipgu_out_ready = 1'b1;
    sum_ready = 1'b0;
    rdn_in_ready = 1'b1;
    #1;
    k = 0;
    while (!sum_go && k < 100) begin
      @(negedge clk);
      ipgu_out_ready = 1'b0;
      #1;
      k++;
    end
    if (!sum_go) fail("wait_sum_go");
    repeat (TO) @(negedge clk);
    #1;
    check("no_err_last_wait_cycle", int'(err_timeout), 0);
    @(negedge clk);
    #1;
    check("err_outputs", int'(outs), 3);
    sum_ready = 1'b1;
    rdn_in_ready = 1'b1;
    ipgu_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", int'(outs), 3);
    @(negedge clk);
    rst = 1'b1;
    ipgu_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("err_cleared_by_reset", int'(err_timeout), 0);
    check("idle_after_err_reset", int'(in_ready), 1);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
